an29_corrector: RTL and testbench
=================================

AN29_CORRECTOR -- requirements
Module: an29_corrector

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating statistics counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream Barrett-stage result is present.
REQ-005 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-006 SHALL have port receive, input, 14, the received codeword.
REQ-007 SHALL have port q, input, 10, the Barrett quotient floor(receive/29).
REQ-008 SHALL have port r, input, 5, the Barrett remainder receive mod 29, range 0..28.
REQ-009 SHALL have port error, input, 1, upstream flag, equal to (r != 0).
REQ-010 SHALL have port out_valid, output, 1, the result is present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port data, output, 10, the decoded (corrected) data word.
REQ-013 SHALL have port corrected, output, 1, a single-bit error was corrected.
REQ-014 SHALL have port uncorrectable, output, 1, the syndrome is inconsistent and data equals q unmodified.
REQ-015 SHALL have port err_pos, output, 4, the corrected bit index i (0..13); 0 when no correction.
REQ-016 SHALL have port err_sign, output, 1, 1 = the error was +2^i (bit flipped 0->1), 0 = -2^i; 0 when no correction.
REQ-017 SHALL have port stat_clr, input, 1, synchronous clear of both counters.
REQ-018 SHALL have port corr_cnt, output, CNT_W, count of corrected words.
REQ-019 SHALL have port fail_cnt, output, CNT_W, count of uncorrectable words.

Function
REQ-020 SHALL use valid/ready handshakes on both sides: transfer occurs when valid and ready are both 1 in the same cycle, and a valid output SHALL hold all output fields stable until it is accepted.
REQ-021 SHALL be a 2-stage pipeline. S1 registers receive, q, r, plus the syndrome lookup (i, sign, hit). S2 registers the corrected result. Latency is 2 cycles from input acceptance to out_valid when there is no stall.
REQ-022 SHALL compute in_ready = !s1_valid || s2_advance, where s2_advance = !s2_valid || out_ready. Full throughput (one word per cycle) SHALL be sustained while out_ready = 1.
REQ-023 SHALL accept in S1 and S2 simultaneously on the same edge when both advance; no word SHALL be dropped or duplicated under any out_ready pattern.
REQ-024 SHALL implement the S1 lookup as follows:
- for r != 0, find the unique i in 0..13 with r == 2^i mod 29 (sign = 1) or r == 29 - (2^i mod 29) (sign = 0);
- the table {1,2,4,8,16,3,6,12,24,19,9,18,7,14} gives the sign = 1 entries for i = 0..13;
- all 28 nonzero residues map to exactly one entry;
- r == 0 gives hit = 0.
REQ-025 SHALL form the S2 result as follows:
- hit = 0: data = q, corrected = 0, uncorrectable = 0;
- sign = 1: requires receive[i] = 1; data = q - floor(2^i/29);
- sign = 0: requires receive[i] = 0; data = q + 1 + floor(2^i/29).
REQ-026 SHALL compute the S2 arithmetic at 11 bits. If the required bit test fails, the result underflows below 0, or the result exceeds 564, then uncorrectable = 1, corrected = 0, and data = q.
REQ-027 SHALL increment corr_cnt or fail_cnt once per accepted output word (out_valid && out_ready) with the matching flag, saturating at all-ones with no wrap.
REQ-028 SHALL give stat_clr priority over an increment in the same cycle: both counters read 0 on the next cycle.
REQ-029 SHALL ignore the error input for decisions; r governs. An error != (r != 0) mismatch SHALL be treated as uncorrectable.

Reset
REQ-030 SHALL, on rst_n = 0 and immediately (asynchronously), clear s1_valid, s2_valid, out_valid, data, corrected, uncorrectable, err_pos, err_sign, corr_cnt and fail_cnt to 0. in_ready SHALL read 1 during and after reset.
REQ-031 SHALL discard any in-flight words on reset mid-operation; the first accepted word after rst_n rises SHALL appear 2 cycles later.

Verification
REQ-032 SHALL pass the clean case: receive = 2900, q = 100, r = 0 -> data = 100, corrected = 0, uncorrectable = 0, out_valid 2 cycles after acceptance.
REQ-033 SHALL pass the +error case: receive = 2908, q = 100, r = 8 -> data = 100, corrected = 1, err_pos = 3, err_sign = 1, corr_cnt increments by 1.
REQ-034 SHALL pass the -error case: receive = 852, q = 29, r = 11 -> data = 100, err_pos = 11, err_sign = 0; and receive = 2896, q = 99, r = 25 -> data = 100, err_pos = 2, err_sign = 0.
REQ-035 SHALL pass the uncorrectable case: receive = 37, q = 1, r = 8 (receive[3] = 0) -> uncorrectable = 1, data = 1, fail_cnt increments by 1.
REQ-036 SHALL pass backpressure: a 10-word stream with out_ready toggling randomly -> outputs in order, none lost or duplicated, outputs held stable while out_valid && !out_ready, in_ready = 0 whenever both stages are full and stalled.
REQ-037 SHALL pass reset and saturation: rst_n pulsed low with 2 words in flight -> out_valid = 0 at once and counters = 0; with CNT_W = 4, 20 corrected words -> corr_cnt = 15; stat_clr coinciding with an increment -> 0.

Source files
------------

// File: rtl/an29_corrector.sv
// AN-code (A = 29) single-bit error corrector: a Barrett-stage result goes in, and the
// decoded word comes out through a 2-stage valid/ready pipeline with saturating statistics.
module an29_corrector #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      receive,
  input  logic [9:0]       q,
  input  logic [4:0]       r,
  input  logic             error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       data,
  output logic             corrected,
  output logic             uncorrectable,
  output logic [3:0]       err_pos,
  output logic             err_sign,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  // 2^i mod 29 and floor(2^i / 29) for i = 0..13
  localparam logic [4:0] POW_MOD [14] = '{
    5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd6, 5'd12, 5'd24, 5'd19, 5'd9, 5'd18, 5'd7, 5'd14
  };
  localparam logic [10:0] POW_DIV [14] = '{
    11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd2, 11'd4, 11'd8, 11'd17, 11'd35, 11'd70,
    11'd141, 11'd282
  };

  logic        s2_advance;
  logic        lk_hit, lk_sign, lk_bad;
  logic [3:0]  lk_pos;

  logic        s1_valid;
  logic [13:0] s1_receive;
  logic [9:0]  s1_q;
  logic        s1_hit, s1_sign, s1_bad;
  logic [3:0]  s1_pos;

  logic [10:0] q_ext, k_val, nx_sum;
  logic        bit_ok;
  logic [9:0]  nx_data;
  logic        nx_corr, nx_unc, nx_sign;
  logic [3:0]  nx_pos;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_comb begin
    lk_hit  = 1'b0;
    lk_sign = 1'b0;
    lk_pos  = 4'd0;
    for (int k = 0; k < 14; k++) begin
      if (r == POW_MOD[k]) begin
        lk_hit  = 1'b1;
        lk_sign = 1'b1;
        lk_pos  = 4'(k);
      end else if (r == 5'd29 - POW_MOD[k]) begin
        lk_hit  = 1'b1;
        lk_sign = 1'b0;
        lk_pos  = 4'(k);
      end
    end
    // A disagreeing upstream flag or an out-of-range residue is an inconsistent syndrome
    lk_bad = (error != (r != 5'd0)) || ((r != 5'd0) && !lk_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_receive <= '0;
      s1_q       <= '0;
      s1_hit     <= 1'b0;
      s1_sign    <= 1'b0;
      s1_bad     <= 1'b0;
      s1_pos     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_receive <= receive;
        s1_q       <= q;
        s1_hit     <= lk_hit;
        s1_sign    <= lk_sign;
        s1_bad     <= lk_bad;
        s1_pos     <= lk_pos;
      end
    end
  end

  // An underflowing subtraction wraps above 2047-282, so the single <= 564 test also catches it
  always_comb begin
    q_ext   = {1'b0, s1_q};
    k_val   = POW_DIV[s1_pos];
    nx_sum  = s1_sign ? (q_ext - k_val) : (q_ext + 11'd1 + k_val);
    bit_ok  = (s1_receive[s1_pos] == s1_sign);
    nx_data = s1_q;
    nx_corr = 1'b0;
    nx_unc  = 1'b0;
    nx_pos  = 4'd0;
    nx_sign = 1'b0;
    if (s1_bad) begin
      nx_unc = 1'b1;
    end else if (s1_hit) begin
      if (bit_ok && (nx_sum <= 11'd564)) begin
        nx_data = nx_sum[9:0];
        nx_corr = 1'b1;
        nx_pos  = s1_pos;
        nx_sign = s1_sign;
      end else begin
        nx_unc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      data          <= '0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      err_pos       <= '0;
      err_sign      <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data          <= nx_data;
        corrected     <= nx_corr;
        uncorrectable <= nx_unc;
        err_pos       <= nx_pos;
        err_sign      <= nx_sign;
      end
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else if (stat_clr) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (corrected && (corr_cnt != '1))
        corr_cnt <= corr_cnt + 1'b1;
      if (uncorrectable && (fail_cnt != '1))
        fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_an29_corrector.sv
// Self-checking bench for an29_corrector: directed syndrome cases plus randomized streams
// checked against an arithmetic reference model; a CNT_W=4 copy exercises saturation.
module tb_an29_corrector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        stat_clr = 1'b0;
  logic        error = 1'b0;
  logic [13:0] receive = '0;
  logic [9:0]  q = '0;
  logic [4:0]  r = '0;

  logic        in_ready, out_valid, corrected, uncorrectable, err_sign;
  logic [9:0]  data;
  logic [3:0]  err_pos;
  logic [15:0] corr_cnt, fail_cnt;

  logic        in_ready4, out_valid4, corrected4, uncorrectable4, err_sign4;
  logic [9:0]  data4;
  logic [3:0]  err_pos4;
  logic [3:0]  corr_cnt4, fail_cnt4;

  int errors = 0;
  int checks = 0;
  int exp_corr = 0, exp_fail = 0, exp_corr4 = 0, exp_fail4 = 0;

  typedef struct {
    logic [9:0] d;
    logic       c;
    logic       u;
    logic [3:0] p;
    logic       s;
  } res_t;

  typedef struct {
    int         rcv;
    int         qv;
    int         rv;
    logic       err;
    res_t       e;
  } vec_t;

  an29_corrector #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .receive(receive), .q(q), .r(r), .error(error),
    .out_valid(out_valid), .out_ready(out_ready), .data(data),
    .corrected(corrected), .uncorrectable(uncorrectable),
    .err_pos(err_pos), .err_sign(err_sign), .stat_clr(stat_clr),
    .corr_cnt(corr_cnt), .fail_cnt(fail_cnt)
  );

  an29_corrector #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .receive(receive), .q(q), .r(r), .error(error),
    .out_valid(out_valid4), .out_ready(out_ready), .data(data4),
    .corrected(corrected4), .uncorrectable(uncorrectable4),
    .err_pos(err_pos4), .err_sign(err_sign4), .stat_clr(stat_clr),
    .corr_cnt(corr_cnt4), .fail_cnt(fail_cnt4)
  );

  always #5 clk = ~clk;

  // Decode straight from the AN-code arithmetic: received = 29*d +/- 2^i
  function automatic res_t model(input int rcv, input int qv, input int rv, input logic err);
    res_t m;
    int   found, k, val;
    logic sgn;
    m.d = 10'(qv); m.c = 1'b0; m.u = 1'b0; m.p = 4'd0; m.s = 1'b0;
    found = -1;
    sgn = 1'b0;
    if (err != (rv != 0)) begin m.u = 1'b1; return m; end
    if (rv == 0) return m;
    for (int i = 0; i < 14; i++) begin
      if (rv == (1 << i) % 29) begin found = i; sgn = 1'b1; end
      if (rv == 29 - (1 << i) % 29) begin found = i; sgn = 1'b0; end
    end
    if (found < 0) begin m.u = 1'b1; return m; end
    k = (1 << found) / 29;
    if (sgn) begin
      if (((rcv >> found) & 1) == 0) begin m.u = 1'b1; return m; end
      val = qv - k;
    end else begin
      if (((rcv >> found) & 1) == 1) begin m.u = 1'b1; return m; end
      val = qv + 1 + k;
    end
    if (val < 0 || val > 564) begin m.u = 1'b1; return m; end
    m.d = 10'(val); m.c = 1'b1; m.p = 4'(found); m.s = sgn;
    return m;
  endfunction

  function automatic void count_word(input res_t e);
    if (e.c) begin
      exp_corr  = (exp_corr < 65535) ? exp_corr + 1 : exp_corr;
      exp_corr4 = (exp_corr4 < 15) ? exp_corr4 + 1 : exp_corr4;
    end
    if (e.u) begin
      exp_fail  = (exp_fail < 65535) ? exp_fail + 1 : exp_fail;
      exp_fail4 = (exp_fail4 < 15) ? exp_fail4 + 1 : exp_fail4;
    end
  endfunction

  task automatic gen_word(output int rcv, output int qv, output int rv, output logic err);
    int d, i, mode;
    mode = int'($urandom_range(0, 3));
    d    = int'($urandom_range(0, 564));
    i    = int'($urandom_range(0, 13));
    case (mode)
      0:       rcv = 29 * d;
      1:       rcv = 29 * d + (1 << i);
      2:       rcv = 29 * d - (1 << i);
      default: rcv = int'($urandom_range(0, 16383));
    endcase
    if (rcv < 0 || rcv > 16383) rcv = 29 * d;
    qv  = rcv / 29;
    rv  = rcv % 29;
    err = (rv != 0);
    if ($urandom_range(0, 15) == 0) err = !err;
  endtask

  // Pushes one word into an empty pipeline and returns at the negedge where out_valid is seen
  task automatic send_word(input int rcv, input int qv, input int rv, input logic err,
                           output int lat);
    @(posedge clk); #1;
    receive = 14'(rcv); q = 10'(qv); r = 5'(rv); error = err;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 8);
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({out_valid, data, corrected, uncorrectable, err_pos, err_sign} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%0d c=%b u=%b p=%0d s=%b expected all 0",
               out_valid, data, corrected, uncorrectable, err_pos, err_sign);
    end
    checks++;
    if (corr_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", corr_cnt, fail_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs[$];
    int   lat;
    vecs.push_back('{2900, 100, 0, 1'b1, '{10'd100, 1'b0, 1'b1, 4'd0, 1'b0}});
    vecs.push_back('{2900, 100, 0, 1'b0, '{10'd100, 1'b0, 1'b0, 4'd0, 1'b0}});
    vecs.push_back('{2908, 100, 8, 1'b1, '{10'd100, 1'b1, 1'b0, 4'd3, 1'b1}});
    vecs.push_back('{852, 29, 11, 1'b1, '{10'd100, 1'b1, 1'b0, 4'd11, 1'b0}});
    vecs.push_back('{2896, 99, 25, 1'b1, '{10'd100, 1'b1, 1'b0, 4'd2, 1'b0}});
    vecs.push_back('{37, 1, 8, 1'b1, '{10'd1, 1'b0, 1'b1, 4'd0, 1'b0}});
    vecs.push_back('{2908, 100, 8, 1'b0, '{10'd100, 1'b0, 1'b1, 4'd0, 1'b0}});
    vecs.push_back('{8192, 282, 14, 1'b1, '{10'd0, 1'b1, 1'b0, 4'd13, 1'b1}});
    vecs.push_back('{8192, 5, 14, 1'b1, '{10'd5, 1'b0, 1'b1, 4'd0, 1'b0}});
    vecs.push_back('{8191, 281, 15, 1'b1, '{10'd564, 1'b1, 1'b0, 4'd13, 1'b0}});
    vecs.push_back('{8191, 282, 15, 1'b1, '{10'd282, 1'b0, 1'b1, 4'd0, 1'b0}});
    vecs.push_back('{0, 0, 30, 1'b1, '{10'd0, 1'b0, 1'b1, 4'd0, 1'b0}});
    vecs.push_back('{1, 10, 28, 1'b1, '{10'd10, 1'b0, 1'b1, 4'd0, 1'b0}});
    foreach (vecs[n]) begin
      send_word(vecs[n].rcv, vecs[n].qv, vecs[n].rv, vecs[n].err, lat);
      checks++;
      if (lat !== 2) begin
        errors++; $display("[TB] FAIL directed_latency case %0d: got %0d expected 2", n, lat);
      end
      checks++;
      if ({data, corrected, uncorrectable, err_pos, err_sign} !==
          {vecs[n].e.d, vecs[n].e.c, vecs[n].e.u, vecs[n].e.p, vecs[n].e.s}) begin
        errors++;
        $display("[TB] FAIL directed_result case %0d: got d=%0d c=%b u=%b p=%0d s=%b expected d=%0d c=%b u=%b p=%0d s=%b",
                 n, data, corrected, uncorrectable, err_pos, err_sign,
                 vecs[n].e.d, vecs[n].e.c, vecs[n].e.u, vecs[n].e.p, vecs[n].e.s);
      end
      count_word(vecs[n].e);
      @(posedge clk); #1;
      checks++;
      if (corr_cnt !== 16'(exp_corr) || fail_cnt !== 16'(exp_fail)) begin
        errors++;
        $display("[TB] FAIL directed_counters case %0d: got %0d/%0d expected %0d/%0d",
                 n, corr_cnt, fail_cnt, exp_corr, exp_fail);
      end
    end
  endtask

  task automatic test_stream(input int n, input int valid_pct, input int ready_pct,
                             output int cyc);
    res_t        expq[$];
    res_t        e;
    int          sent, got, pending, rcv, qv, rv;
    logic        err, acc, held;
    logic [16:0] hold_val;
    sent = 0; got = 0; pending = 0; cyc = 0;
    acc = 1'b0; held = 1'b0; hold_val = '0;
    in_valid = 1'b0;
    while (got < n && cyc < 20 * n + 50) begin
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        if (sent < n && int'($urandom_range(0, 99)) < valid_pct) begin
          gen_word(rcv, qv, rv, err);
          receive = 14'(rcv); q = 10'(qv); r = 5'(rv); error = err;
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      @(negedge clk);
      cyc++;
      if (held) begin
        checks++;
        if (!out_valid || {data, corrected, uncorrectable, err_pos, err_sign} !== hold_val) begin
          errors++;
          $display("[TB] FAIL stream_hold word %0d: got v=%b fields=%h expected v=1 fields=%h",
                   got, out_valid, {data, corrected, uncorrectable, err_pos, err_sign}, hold_val);
        end
      end
      checks++;
      if (in_ready !== ((pending < 2) || out_ready)) begin
        errors++;
        $display("[TB] FAIL stream_in_ready: got %b expected %b (in flight %0d, out_ready %b)",
                 in_ready, (pending < 2) || out_ready, pending, out_ready);
      end
      if (out_valid && pending == 0) begin
        errors++; checks++;
        $display("[TB] FAIL stream_spurious: got out_valid=1 expected 0 with nothing in flight");
      end
      held = 1'b0;
      if (out_valid && out_ready && pending > 0) begin
        e = expq.pop_front();
        checks++;
        if ({data, corrected, uncorrectable, err_pos, err_sign} !== {e.d, e.c, e.u, e.p, e.s}) begin
          errors++;
          $display("[TB] FAIL stream_word %0d: got d=%0d c=%b u=%b p=%0d s=%b expected d=%0d c=%b u=%b p=%0d s=%b",
                   got, data, corrected, uncorrectable, err_pos, err_sign, e.d, e.c, e.u, e.p, e.s);
        end
        count_word(e);
        got++;
        pending--;
      end else if (out_valid) begin
        held = 1'b1;
        hold_val = {data, corrected, uncorrectable, err_pos, err_sign};
      end
      acc = in_valid && in_ready;
      if (acc) begin
        expq.push_back(model(int'(receive), int'(q), int'(r), error));
        sent++;
        pending++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != n) begin
      errors++; $display("[TB] FAIL stream_timeout: got %0d words expected %0d", got, n);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (corr_cnt !== 16'(exp_corr) || fail_cnt !== 16'(exp_fail) ||
        corr_cnt4 !== 4'(exp_corr4) || fail_cnt4 !== 4'(exp_fail4)) begin
      errors++;
      $display("[TB] FAIL stream_counters: got %0d/%0d %0d/%0d expected %0d/%0d %0d/%0d",
               corr_cnt, fail_cnt, corr_cnt4, fail_cnt4, exp_corr, exp_fail, exp_corr4, exp_fail4);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    test_stream(10, 90, 50, cyc);
    test_stream(300, 80, 60, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    test_stream(60, 100, 100, cyc);
    checks++;
    if (cyc !== 62) begin
      errors++; $display("[TB] FAIL back_to_back_cycles: got %0d expected 62", cyc);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(posedge clk); #1;
    receive = 14'd2908; q = 10'd100; r = 5'd8; error = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_stall: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, data, corrected, uncorrectable, err_pos, err_sign} !== 18'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got v=%b d=%0d c=%b u=%b p=%0d s=%b rdy=%b expected zeros, rdy=1",
               out_valid, data, corrected, uncorrectable, err_pos, err_sign, in_ready);
    end
    checks++;
    if (corr_cnt !== 16'd0 || fail_cnt !== 16'd0 || corr_cnt4 !== 4'd0 || fail_cnt4 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_counters: got %0d/%0d %0d/%0d expected all 0",
               corr_cnt, fail_cnt, corr_cnt4, fail_cnt4);
    end
    exp_corr = 0; exp_fail = 0; exp_corr4 = 0; exp_fail4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flush: got out_valid=%b expected 0", out_valid);
    end
    send_word(2908, 100, 8, 1'b1, lat);
    checks++;
    if (lat !== 2 || data !== 10'd100 || corrected !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_word: got lat=%0d d=%0d c=%b expected 2/100/1", lat, data, corrected);
    end
    exp_corr = 1; exp_corr4 = 1;
    @(posedge clk); #1;
    checks++;
    if (corr_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL post_reset_count: got %0d expected 1", corr_cnt);
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    receive = 14'd2908; q = 10'd100; r = 5'd8; error = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_corr = exp_corr + 20;
    exp_corr4 = 15;
    checks++;
    if (corr_cnt4 !== 4'd15) begin
      errors++; $display("[TB] FAIL saturate_cnt4: got %0d expected 15", corr_cnt4);
    end
    checks++;
    if (corr_cnt !== 16'(exp_corr)) begin
      errors++; $display("[TB] FAIL saturate_cnt16: got %0d expected %0d", corr_cnt, exp_corr);
    end
  endtask

  task automatic test_stat_clr();
    int w, lat;
    @(posedge clk); #1;
    receive = 14'd37; q = 10'd1; r = 5'd8; error = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 8);
    checks++;
    if (out_valid !== 1'b1 || uncorrectable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_setup: got v=%b u=%b expected 1/1", out_valid, uncorrectable);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    exp_corr = 0; exp_fail = 0; exp_corr4 = 0; exp_fail4 = 0;
    checks++;
    if (corr_cnt !== 16'd0 || fail_cnt !== 16'd0 || corr_cnt4 !== 4'd0 || fail_cnt4 !== 4'd0 ||
        out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_priority: got %0d/%0d %0d/%0d v=%b expected 0/0 0/0 v=0",
               corr_cnt, fail_cnt, corr_cnt4, fail_cnt4, out_valid);
    end
    send_word(852, 29, 11, 1'b1, lat);
    @(posedge clk); #1;
    checks++;
    if (corr_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL clr_resume: got %0d/%0d expected 1/0", corr_cnt, fail_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    test_stat_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
